// File: rtl/lsu.sv
// Load/store unit: one outstanding byte/halfword/word access, split into two
// word-aligned bus beats when misaligned, with sign/zero-extended load results.
module lsu #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_req_i,
   input  logic          mem_we_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic [DW-1:0] mem_wdata_i,
   input  logic [2:0]    byte_sel_i,
   output logic [DW-1:0] rdata_o,
   output logic          done_o,
   output logic          hold_o,
   output logic          bus_req_o,
   output logic          bus_we_o,
   output logic [AW-1:0] bus_addr_o,
   output logic [3:0]    bus_be_o,
   output logic [DW-1:0] bus_wdata_o,
   input  logic          bus_gnt_i,
   input  logic          bus_rvalid_i,
   input  logic [DW-1:0] bus_rdata_i
);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

   state_t        state;
   logic          we_q;
   logic          split_q;
   logic [1:0]    k_q;
   logic [2:0]    sel_q;
   logic [AW-1:0] addr_q;
   logic [3:0]    be1_q;
   logic [DW-1:0] wdata1_q;
   logic [DW-1:0] lo_q;

   logic [3:0]      mask_n;
   logic [7:0]      be_n;
   logic [2*DW-1:0] wdata_n;

   // Lane placement of the incoming request across a two-word window.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      mask_n = 4'b1111;
      case (byte_sel_i)
         3'b000, 3'b100: mask_n = 4'b0001;
         3'b001, 3'b101: mask_n = 4'b0011;
         default:        mask_n = 4'b1111;
      endcase
      be_n    = {4'b0000, mask_n} << mem_addr_i[1:0];
      wdata_n = {{DW{1'b0}}, mem_wdata_i} << {mem_addr_i[1:0], 3'b000};
   end

   function automatic logic [DW-1:0] extend(input logic [2*DW-1:0] pair,
                                            input logic [1:0]      k,
                                            input logic [2:0]      sel);
      logic [2*DW-1:0] shifted;
      logic [DW-1:0]   raw;
      shifted = pair >> {k, 3'b000};
      raw     = shifted[DW-1:0];
      case (sel)
         3'b000:  extend = {{(DW-8){raw[7]}}, raw[7:0]};
         3'b100:  extend = {{(DW-8){1'b0}}, raw[7:0]};
         3'b001:  extend = {{(DW-16){raw[15]}}, raw[15:0]};
         3'b101:  extend = {{(DW-16){1'b0}}, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   assign hold_o = (state == IDLE && mem_req_i) ||
                   state == REQ0 || state == WAIT0 || state == REQ1 || state == WAIT1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done_o      <= 1'b0;
         rdata_o     <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
      // NOTE: the captured request/datapath registers are not reset; each is written at capture before it is read.
      end else begin
         done_o  <= 1'b0;
         rdata_o <= '0;
         // A beat's bus signals hold until granted, then drop unless a new beat is launched below.
         if (!bus_req_o || bus_gnt_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
         end
         case (state)
            IDLE: if (mem_req_i) begin
               we_q        <= mem_we_i;
               k_q         <= mem_addr_i[1:0];
               sel_q       <= byte_sel_i;
               split_q     <= |be_n[7:4];
               addr_q      <= {mem_addr_i[AW-1:2], 2'b00};
               be1_q       <= be_n[7:4];
               wdata1_q    <= wdata_n[2*DW-1:DW];
               bus_req_o   <= 1'b1;
               bus_we_o    <= mem_we_i;
               bus_addr_o  <= {mem_addr_i[AW-1:2], 2'b00};
               bus_be_o    <= be_n[3:0];
               bus_wdata_o <= wdata_n[DW-1:0];
               state       <= REQ0;
            end
            REQ0: if (bus_gnt_i) begin
               if (we_q && split_q) begin
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b1;
                  bus_addr_o  <= addr_q + AW'(4);
                  bus_be_o    <= be1_q;
                  bus_wdata_o <= wdata1_q;
                  state       <= REQ1;
               end else if (we_q) begin
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  state <= WAIT0;
               end
            end
            WAIT0: if (bus_rvalid_i) begin
               lo_q <= bus_rdata_i;
               if (split_q) begin
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= addr_q + AW'(4);
                  bus_be_o    <= be1_q;
                  bus_wdata_o <= '0;
                  state       <= REQ1;
               end else begin
                  done_o  <= 1'b1;
                  rdata_o <= extend({{DW{1'b0}}, bus_rdata_i}, k_q, sel_q);
                  state   <= DONE;
               end
            end
            REQ1: if (bus_gnt_i) begin
               if (we_q) begin
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  state <= WAIT1;
               end
            end
            WAIT1: if (bus_rvalid_i) begin
               done_o  <= 1'b1;
               rdata_o <= extend({bus_rdata_i, lo_q}, k_q, sel_q);
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-level memory model feeds a scoreboard of
// expected bus beats and load results; a monitor compares as the DUT presents them.
module tb_lsu;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_req_i, mem_we_i;
   logic [AW-1:0] mem_addr_i;
   logic [DW-1:0] mem_wdata_i;
   logic [2:0]    byte_sel_i;
   logic [DW-1:0] rdata_o;
   logic          done_o, hold_o;
   logic          bus_req_o, bus_we_o;
   logic [AW-1:0] bus_addr_o;
   logic [3:0]    bus_be_o;
   logic [DW-1:0] bus_wdata_o;
   logic          bus_gnt_i, bus_rvalid_i;
   logic [DW-1:0] bus_rdata_i;

   always #5 clk = ~clk;

   lsu #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .byte_sel_i(byte_sel_i),
      .rdata_o(rdata_o), .done_o(done_o), .hold_o(hold_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Bus-side memory: a fixed hash per word, with directed overrides.
   logic [31:0] ovr [logic [31:0]];

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      if (ovr.exists(a)) return ovr[a];
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   beat_t       beat_q[$];
   logic [31:0] res_q[$];

   // Reference model: walk the accessed bytes one by one in little-endian order.
   task automatic push_expect(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sel);
      int          n;
      int          lane;
      beat_t       b0, b1;
      logic [31:0] w0, ba, bw, word, val;
      n  = (sel == 3'd0 || sel == 3'd4) ? 1 : (sel == 3'd1 || sel == 3'd5) ? 2 : 4;
      w0 = {a[31:2], 2'b00};
      b0 = '{addr: w0, be: 4'b0, we: we, wdata: 32'h0};
      b1 = '{addr: w0 + 32'd4, be: 4'b0, we: we, wdata: 32'h0};
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
         ba   = a + 32'(i);
         bw   = {ba[31:2], 2'b00};
         lane = int'(ba[1:0]);
         if (bw == w0) begin
            b0.be[lane] = 1'b1;
            b0.wdata[lane*8 +: 8] = wd[i*8 +: 8];
         end else begin
            b1.be[lane] = 1'b1;
            b1.wdata[lane*8 +: 8] = wd[i*8 +: 8];
         end
         word = bus_word(bw);
         val[i*8 +: 8] = word[lane*8 +: 8];
      end
      case (sel)
         3'd0:    val = {{24{val[7]}}, val[7:0]};
         3'd1:    val = {{16{val[15]}}, val[15:0]};
         default: ;
      endcase
      beat_q.push_back(b0);
      if (b1.be != 4'b0) beat_q.push_back(b1);
      res_q.push_back(we ? 32'h0 : val);
   endtask

   // Bus responder with programmable grant/rvalid delays and optional noise.
   int          gnt_dly = 0, rv_dly = 0, gnt_cnt = 0, rv_cnt = 0;
   bit          pend_rv = 0, prev_req = 0, noise = 0;
   logic [31:0] pend_data;

   initial begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      forever begin
         @(posedge clk); #1;
         bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
         if (pend_rv) begin
            if (rv_cnt == 0) begin
               bus_rvalid_i = 1'b1; bus_rdata_i = pend_data; pend_rv = 0;
            end else rv_cnt--;
         end else if (noise && $urandom_range(0, 3) == 0) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
         end
         if (bus_req_o === 1'b1) begin
            if (!prev_req) gnt_cnt = gnt_dly;
            if (gnt_cnt == 0) begin
               bus_gnt_i = 1'b1;
               gnt_cnt   = gnt_dly;
               if (!bus_we_o) begin
                  pend_rv = 1; pend_data = bus_word(bus_addr_o); rv_cnt = rv_dly;
               end
            end else gnt_cnt--;
         end else if (noise && $urandom_range(0, 3) == 0) begin
            bus_gnt_i = 1'b1;
         end
         prev_req = (bus_req_o === 1'b1);
      end
   end

   // Monitor: pops the scoreboard whenever a beat is accepted or done_o pulses.
   bit          mon_en = 0, prev_wait = 0;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_be;
   logic        p_we;
   beat_t       mb;
   logic [31:0] mres, wmask;

   initial begin
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 0;
            continue;
         end
         if (prev_wait) begin
            check("req_held", bus_req_o === 1'b1, 64'(bus_req_o), 64'd1);
            check("stable_addr_be_we", {bus_we_o, bus_be_o, bus_addr_o} === {p_we, p_be, p_addr},
                  {bus_be_o, bus_addr_o}, {p_be, p_addr});
            check("stable_wdata", bus_wdata_o === p_wdata, 64'(bus_wdata_o), 64'(p_wdata));
         end
         if (bus_req_o && bus_gnt_i) begin
            if (beat_q.size() == 0) begin
               check("beat_unexpected", 1'b0, 64'(bus_addr_o), 64'd0);
            end else begin
               mb = beat_q.pop_front();
               check("beat_addr", bus_addr_o === mb.addr, 64'(bus_addr_o), 64'(mb.addr));
               check("beat_be", bus_be_o === mb.be, 64'(bus_be_o), 64'(mb.be));
               check("beat_we", bus_we_o === mb.we, 64'(bus_we_o), 64'(mb.we));
               if (mb.we) begin
                  for (int l = 0; l < 4; l++) wmask[l*8 +: 8] = {8{mb.be[l]}};
                  check("beat_wdata", (bus_wdata_o & wmask) === mb.wdata,
                        64'(bus_wdata_o & wmask), 64'(mb.wdata));
               end
            end
         end
         if (!bus_req_o)
            check("bus_idle_zero", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} === '0,
                  {bus_addr_o, bus_wdata_o}, 64'd0);
         if (done_o) begin
            if (res_q.size() == 0) begin
               check("done_unexpected", 1'b0, 64'(rdata_o), 64'd0);
            end else begin
               mres = res_q.pop_front();
               check("rdata", rdata_o === mres, 64'(rdata_o), 64'(mres));
            end
         end else begin
            check("rdata_zero", rdata_o === '0, 64'(rdata_o), 64'd0);
         end
         prev_wait = bus_req_o && !bus_gnt_i;
         p_addr = bus_addr_o; p_be = bus_be_o; p_we = bus_we_o; p_wdata = bus_wdata_o;
      end
   end

   // One instruction: present the request, hold it until done, then release.
   task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sel, input int gd, input int rd, input int exp_lat);
      int cycles;
      bit seen;
      gnt_dly = gd; rv_dly = rd;
      push_expect(we, a, wd, sel);
      @(negedge clk);
      mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = wd; byte_sel_i = sel;
      #1 check("hold_on_req", hold_o === 1'b1, 64'(hold_o), 64'd1);
      cycles = 0; seen = 0;
      while (!seen && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (done_o === 1'b1) seen = 1;
         else check("hold_busy", hold_o === 1'b1, 64'(hold_o), 64'd1);
      end
      check("done_seen", seen, 64'(cycles), 64'(exp_lat));
      if (seen) begin
         check("hold_released", hold_o === 1'b0, 64'(hold_o), 64'd0);
         if (exp_lat > 0) check("latency", cycles == exp_lat, 64'(cycles), 64'(exp_lat));
      end
      @(negedge clk);
      mem_req_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; byte_sel_i = '0;
      ovr[32'h200] = 32'h80FF_FF12;
      ovr[32'h300] = 32'h4433_2211;
      ovr[32'h304] = 32'h8877_6655;

      repeat (3) @(negedge clk);
      check("rst_bus_req", bus_req_o === 1'b0, 64'(bus_req_o), 64'd0);
      check("rst_bus_fields", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} === '0,
            {bus_addr_o, bus_wdata_o}, 64'd0);
      check("rst_done", done_o === 1'b0, 64'(done_o), 64'd0);
      check("rst_rdata", rdata_o === '0, 64'(rdata_o), 64'd0);
      check("rst_hold_idle", hold_o === 1'b0, 64'(hold_o), 64'd0);
      rst = 1'b0;
      mon_en = 1;

      do_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, 0, 2);       // SW aligned
      do_txn(1'b0, 32'h203, 32'h0, 3'b000, 0, 0, 3);               // LB
      do_txn(1'b0, 32'h203, 32'h0, 3'b100, 0, 0, 3);               // LBU
      do_txn(1'b0, 32'h301, 32'h0, 3'b010, 0, 0, 5);               // split LW
      do_txn(1'b1, 32'hFFFF_FFFF, 32'h0000_ABCD, 3'b001, 0, 0, 3); // split SH, wraps
      do_txn(1'b0, 32'h12, 32'h0, 3'b101, 3, 2, 8);                // LHU, slow bus

      // Reset in WAIT0 with rvalid arriving the cycle after.
      gnt_dly = 0; rv_dly = 1;
      push_expect(1'b0, 32'h40, 32'h0, 3'b000);
      void'(res_q.pop_back());
      @(negedge clk);
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40; byte_sel_i = 3'b000;
      @(negedge clk);
      @(negedge clk);
      check("hold_wait0", hold_o === 1'b1, 64'(hold_o), 64'd1);
      rst = 1'b1; mem_req_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_req", bus_req_o === 1'b0, 64'(bus_req_o), 64'd0);
      check("abort_done", done_o === 1'b0, 64'(done_o), 64'd0);
      check("abort_hold", hold_o === 1'b0, 64'(hold_o), 64'd0);
      repeat (4) @(negedge clk);
      do_txn(1'b1, 32'h1, 32'h5A, 3'b000, 0, 0, 2);                // SB after abort

      noise = 1;
      for (int t = 0; t < 150; t++) begin
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         do_txn(1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end
      noise = 0;

      repeat (10) @(negedge clk);
      check("beats_drained", beat_q.size() == 0, 64'(beat_q.size()), 64'd0);
      check("results_drained", res_q.size() == 0, 64'(res_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
